// File: rtl/i2s_transmitter_if.sv
// Sample handshake bundle between a PCM source and the I2S transmitter.
// The source drives the stereo pair and valid; the transmitter returns ready.
interface i2s_transmitter_if;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: 16-bit stereo PCM to bclk/lrclk/data.
// Define I2S_TX_LJ_EN for left-justified framing (no one-bclk data delay).
module i2s_transmitter #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    i2s_transmitter_if.slave smp,
    output logic             i2s_bclk,
    output logic             i2s_lrclk,
    output logic             i2s_data,
    output logic             frame_strobe,
    output logic             underrun
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CW    = $clog2(FRAME);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] SLOT     = CW'(SLOT_BITS);
    localparam logic [CW-1:0] PAD      = CW'(16);
`ifdef I2S_TX_LJ_EN
    localparam logic [CW-1:0] LOAD_CNT = '0;
`else
    localparam logic [CW-1:0] LOAD_CNT = CW'(1);
`endif

    logic [DW-1:0] div_cnt;
    logic [CW-1:0] bit_cnt;
    logic [15:0]   buf_l;
    logic [15:0]   buf_r;
    logic          buf_full;
    logic [15:0]   word_l;
    logic [15:0]   word_r;

    logic          tick;
    logic          fall;
    logic          load;
    logic          accept;
    logic          right;
    logic          bit_out;
    logic [CW-1:0] bit_nxt;
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [3:0]    idx;
    logic [15:0]   nxt_l;
    logic [15:0]   nxt_r;

    assign smp.sample_ready = !buf_full;

    always_comb begin
        tick    = (div_cnt == DIV_LAST);
        fall    = tick && i2s_bclk;
        bit_nxt = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CW'(1);
`ifdef I2S_TX_LJ_EN
        g       = bit_nxt;
`else
        g       = (bit_nxt == '0) ? CNT_LAST : bit_nxt - CW'(1);
`endif
        load    = fall && (bit_nxt == LOAD_CNT);
        accept  = smp.sample_valid && !buf_full;
        // The bit leaving on a load edge must come from the pair being loaded
        nxt_l   = (load && buf_full) ? buf_l : word_l;
        nxt_r   = (load && buf_full) ? buf_r : word_r;
        right   = (g >= SLOT);
        p       = right ? g - SLOT : g;
        idx     = 4'd15 - p[3:0];
        bit_out = 1'b0;
        if (p < PAD) begin
            bit_out = right ? nxt_r[idx] : nxt_l[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            i2s_bclk     <= 1'b0;
            i2s_lrclk    <= 1'b0;
            i2s_data     <= 1'b0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
            buf_l        <= '0;
            buf_r        <= '0;
            buf_full     <= 1'b0;
            word_l       <= '0;
            word_r       <= '0;
        end else begin
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
            div_cnt      <= tick ? '0 : div_cnt + DW'(1);
            if (tick) begin
                i2s_bclk <= !i2s_bclk;
            end
            if (fall) begin
                bit_cnt   <= bit_nxt;
                i2s_lrclk <= (bit_nxt >= SLOT);
                i2s_data  <= bit_out;
            end
            if (load) begin
                word_l       <= nxt_l;
                word_r       <= nxt_r;
                frame_strobe <= 1'b1;
                underrun     <= !buf_full;
            end
            if (load && buf_full) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full <= 1'b1;
            end
            if (accept) begin
                buf_l <= smp.sample_l;
                buf_r <= smp.sample_r;
            end
        end
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: timeline model of the I2S stream plus literal pins.
// A second instance with 24-bit slots exercises zero padding.
module tb_i2s_transmitter;
    localparam int BD        = 2;
    localparam int SB        = 16;
    localparam int FR        = 2 * SB;
    localparam int FRAME_CLK = FR * 2 * BD;
`ifdef I2S_TX_LJ_EN
    localparam int LOADK      = 0;
    localparam int FIRST_LOAD = FRAME_CLK;
`else
    localparam int LOADK      = 1;
    localparam int FIRST_LOAD = 2 * BD;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    i2s_transmitter_if smp ();
    i2s_transmitter_if smp24 ();

    logic bclk, lrclk, data, fs, ur;
    logic bclk24, lrclk24, data24, fs24, ur24;

    i2s_transmitter #(.BCLK_DIV(BD), .SLOT_BITS(SB)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .smp          (smp),
        .i2s_bclk     (bclk),
        .i2s_lrclk    (lrclk),
        .i2s_data     (data),
        .frame_strobe (fs),
        .underrun     (ur)
    );

    i2s_transmitter #(.BCLK_DIV(BD), .SLOT_BITS(24)) u_dut24 (
        .clk          (clk),
        .reset        (reset),
        .smp          (smp24),
        .i2s_bclk     (bclk24),
        .i2s_lrclk    (lrclk24),
        .i2s_data     (data24),
        .frame_strobe (fs24),
        .underrun     (ur24)
    );

    int vectors = 0;
    int errors  = 0;
    int ur_cnt  = 0;
    bit run     = 0;

    // Timeline model: n = clk edges since reset release, k = bclk falls so far
    int          n = 0;
    int          k = 0;
    int          g = 0;
    logic        m_full  = 1'b0;
    logic [15:0] m_buf_l = '0;
    logic [15:0] m_buf_r = '0;
    logic [15:0] m_act_l = '0;
    logic [15:0] m_act_r = '0;
    logic        e_bclk = 1'b0, e_lr = 1'b0, e_data = 1'b0;
    logic        e_fs = 1'b0, e_ur = 1'b0;
    logic        acc, ld;

    function automatic logic bit_of(input logic [15:0] l, input logic [15:0] r, input int gi);
        int p;
        p = (gi >= SB) ? gi - SB : gi;
        if (p >= 16) return 1'b0;
        return (gi >= SB) ? r[15-p] : l[15-p];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n = 0;
            k = 0;
            m_full = 1'b0;
            m_buf_l = '0;
            m_buf_r = '0;
            m_act_l = '0;
            m_act_r = '0;
            {e_bclk, e_lr, e_data, e_fs, e_ur} = '0;
        end else begin
            acc  = smp.sample_valid && !m_full;
            n    = n + 1;
            k    = n / (2 * BD);
            ld   = (n % (2 * BD) == 0) && (k % FR == LOADK);
            e_fs = ld;
            e_ur = ld && !m_full;
            if (ld && m_full) begin
                m_act_l = m_buf_l;
                m_act_r = m_buf_r;
                m_full  = 1'b0;
            end
            if (acc) begin
                m_buf_l = smp.sample_l;
                m_buf_r = smp.sample_r;
                m_full  = 1'b1;
            end
            e_bclk = ((n / BD) % 2) == 1;
            e_lr   = (k % FR) >= SB;
`ifdef I2S_TX_LJ_EN
            g = k % FR;
`else
            g = (k % FR + FR - 1) % FR;
`endif
            e_data = bit_of(m_act_l, m_act_r, g);
        end
    end

    always @(negedge clk) begin
        if (run && reset === 1'b1) begin
            vectors++;
            if ({bclk, lrclk, data, fs, ur, smp.sample_ready} !==
                {e_bclk, e_lr, e_data, e_fs, e_ur, !m_full}) begin
                errors++;
                $display("FAIL stream n=%0d bclk,lr,data,fs,ur,ready got %b need %b", n,
                         {bclk, lrclk, data, fs, ur, smp.sample_ready},
                         {e_bclk, e_lr, e_data, e_fs, e_ur, !m_full});
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && ur === 1'b1) ur_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h need %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push(input bit w24, input logic [15:0] l, input logic [15:0] r);
        int t = 0;
        if (w24) begin
            smp24.sample_l = l;
            smp24.sample_r = r;
            smp24.sample_valid = 1'b1;
        end else begin
            smp.sample_l = l;
            smp.sample_r = r;
            smp.sample_valid = 1'b1;
        end
        while ((w24 ? smp24.sample_ready : smp.sample_ready) !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            vectors++;
            errors++;
            $display("FAIL push_timeout got no ready need ready within 1000 clk");
        end
        @(negedge clk);
        check("ready_drop", w24 ? smp24.sample_ready : smp.sample_ready, 32'd0);
    endtask

    // Collect bits on bclk rises starting at the next load strobe
    task automatic capture(input bit w24, input int nbits,
                           output logic [31:0] word, output logic ur_s);
        int t = 0;
        int got = 0;
        logic pb, cb;
        word = '0;
        ur_s = 1'b0;
        while ((w24 ? fs24 : fs) !== 1'b1 && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (t >= 600) begin
            vectors++;
            errors++;
            $display("FAIL capture_strobe got none need frame_strobe within 600 clk");
            return;
        end
        ur_s = w24 ? ur24 : ur;
        pb = w24 ? bclk24 : bclk;
        while (got < nbits && t < 1200) begin
            @(negedge clk);
            t++;
            cb = w24 ? bclk24 : bclk;
            if (cb && !pb) begin
                word = {word[30:0], (w24 ? data24 : data)};
                got++;
            end
            pb = cb;
        end
        if (got < nbits) check("capture_bits", got, nbits);
    endtask

    task automatic wait_n(input int target);
        int t = 0;
        while (n < target && t < 5000) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish need finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic        cu;
        int          first, second, t, u0, lt, cnt;
        logic        pl, cl, pb;

        smp.sample_valid = 1'b0;
        smp.sample_l = '0;
        smp.sample_r = '0;
        smp24.sample_valid = 1'b0;
        smp24.sample_l = '0;
        smp24.sample_r = '0;
        #2;
        check("reset_outs", {26'd0, bclk, lrclk, data, fs, ur, smp.sample_ready}, 32'h1);
        check("reset_outs24", {26'd0, bclk24, lrclk24, data24, fs24, ur24, smp24.sample_ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run = 1;

        // Idle source: every load is an underrun, one per frame
        first = -1;
        second = -1;
        t = 0;
        while (second < 0 && t < 400) begin
            @(negedge clk);
            t++;
            if (fs === 1'b1) begin
                check("idle_underrun", ur, 32'd1);
                if (first < 0) first = n;
                else second = n;
            end
        end
        check("first_load_n", first, FIRST_LOAD);
        check("load_period", second - first, FRAME_CLK);

        do_reset();
        push(0, 16'hA5C3, 16'h8001);
        smp.sample_valid = 1'b0;
        capture(0, 32, w, cu);
        check("pair_a5c3_8001", w, 32'hA5C38001);
        check("pair_no_underrun", cu, 32'd0);

        do_reset();
        u0 = ur_cnt;
        push(0, 16'h1111, 16'h2222);
        push(0, 16'h3333, 16'h4444);
        push(0, 16'h5555, 16'h6666);
        smp.sample_valid = 1'b0;
        capture(0, 32, w, cu);
        check("third_pair", w, 32'h55556666);
        check("stream_underruns", ur_cnt - u0, 32'd0);

        for (int i = 0; i < 2500; i++) begin
            smp.sample_valid = ($urandom_range(0, 3) == 0);
            smp.sample_l = 16'($urandom);
            smp.sample_r = 16'($urandom);
            @(negedge clk);
        end
        smp.sample_valid = 1'b0;

        // Offer a pair exactly on the load edge with the buffer empty
        lt = FIRST_LOAD + FRAME_CLK * ((n + 2 * FRAME_CLK - FIRST_LOAD) / FRAME_CLK);
        wait_n(lt - 1);
        smp.sample_l = 16'h1357;
        smp.sample_r = 16'h2468;
        smp.sample_valid = 1'b1;
        @(negedge clk);
        smp.sample_valid = 1'b0;
        check("race_underrun", ur, 32'd1);
        check("race_strobe", fs, 32'd1);
        check("race_ready", smp.sample_ready, 32'd0);
        repeat (4) @(negedge clk);
        capture(0, 32, w, cu);
        check("race_next_frame", w, 32'h13572468);

        do_reset();
        push(0, 16'hDEAD, 16'hBEEF);
        smp.sample_valid = 1'b0;
        push(0, 16'hCAFE, 16'hF00D);
        smp.sample_valid = 1'b0;
        wait_n(FIRST_LOAD + 2 * BD * (SB + 4) + 1);
        check("mid_right_slot", lrclk, 32'd1);
        #3 reset = 1'b0;
        #1;
        check("async_reset_outs", {26'd0, bclk, lrclk, data, fs, ur, smp.sample_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        capture(0, 32, w, cu);
        check("buffer_discarded", w, 32'h0);
        check("restart_underrun", cu, 32'd1);

        do_reset();
        push(1, 16'h7FFF, 16'h0000);
        smp24.sample_valid = 1'b0;
        capture(1, 24, w, cu);
        check("pad24_left", w, 32'h007FFF00);

        t = 0;
        pl = lrclk24;
        while (!(pl === 1'b1 && lrclk24 === 1'b0) && t < 600) begin
            pl = lrclk24;
            @(negedge clk);
            t++;
        end
        cnt = 0;
        pb = bclk24;
        pl = lrclk24;
        cl = lrclk24;
        while (!(pl === 1'b1 && cl === 1'b0) && t < 1200) begin
            pl = cl;
            @(negedge clk);
            t++;
            cl = lrclk24;
            if (bclk24 === 1'b1 && pb === 1'b0) cnt++;
            pb = bclk24;
        end
        check("lrclk_period24", cnt, 32'd48);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
